// File: rtl/battle_sequencer_pkg.sv
// Shared phase codes, UART key codes and HP defaults for the battle sequencer.
package battle_sequencer_pkg;

  typedef enum logic [2:0] {
    PH_IDLE   = 3'd0,
    PH_MENU   = 3'd1,
    PH_ATTACK = 3'd2,
    PH_DODGE  = 3'd3,
    PH_WIN    = 3'd4,
    PH_LOSE   = 3'd5
  } phase_t;

  localparam logic [7:0] KEY_ENTER   = 8'h0D;
  localparam logic [7:0] KEY_ATTACK  = 8'h61;
  localparam logic [7:0] KEY_HEAL    = 8'h68;
  localparam logic [7:0] KEY_RESTART = 8'h72;

  localparam int P_HP_DEFAULT   = 100;
  localparam int MON_HP_DEFAULT = 100;

endpackage

// File: rtl/battle_sequencer_sat_sub8.sv
// 8-bit subtract clamped at zero; purely combinational, no flow control.
module sat_sub8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] y
);

  assign y = (a > b) ? (a - b) : 8'd0;

endmodule

// File: rtl/battle_sequencer.sv
// Turn-based battle FSM: menu, attack gauge, timed bullet dodge, win/lose/restart.
// Inputs act in the cycle sampled, all outputs register on the next clk edge; no backpressure.
module battle_sequencer
  import battle_sequencer_pkg::*;
#(
  parameter int DODGE_TICKS = 50,
  parameter int P_HP_INIT   = P_HP_DEFAULT,
  parameter int MON_HP_INIT = MON_HP_DEFAULT,
  parameter int HEAL_AMT    = 10,
  parameter int NUM_WAVES   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       key_valid,
  input  logic [7:0] key,
  input  logic       atk_done,
  input  logic [7:0] atk_dmg,
  input  logic       hit_pulse,
  input  logic [7:0] hit_dmg,
  output logic [2:0] phase,
  output logic       atk_start,
  output logic       bullet_run,
  output logic [2:0] wave_idx,
  output logic [7:0] mon_hp,
  output logic [7:0] p_hp,
  output logic       game_over,
  output logic       win
);

  localparam int CNT_W = $clog2(DODGE_TICKS + 1);

  phase_t           state, nextState;
  logic [CNT_W-1:0] tickCnt, nextCnt, cntInc;
  logic [7:0]       nextPHp, nextMonHp, pHpHit, monHpHit;
  logic [2:0]       nextWave, waveInc;
  logic [8:0]       healSum;
  logic             nextAtkStart, nextBulletRun, nextWin, nextGameOver;
  logic             keyEnter, keyAttack, keyHeal, keyRestart;

  sat_sub8 uPlayerSub (.a(p_hp),   .b(hit_dmg), .y(pHpHit));
  sat_sub8 uMonSub    (.a(mon_hp), .b(atk_dmg), .y(monHpHit));

  assign keyEnter   = key_valid && (key == KEY_ENTER);
  assign keyAttack  = key_valid && (key == KEY_ATTACK);
  assign keyHeal    = key_valid && (key == KEY_HEAL);
  assign keyRestart = key_valid && (key == KEY_RESTART);

  assign cntInc  = tickCnt + CNT_W'(1);
  assign waveInc = (wave_idx == 3'(NUM_WAVES - 1)) ? 3'd0 : wave_idx + 3'd1;
  assign healSum = {1'b0, p_hp} + 9'(HEAL_AMT);
  assign phase   = state;

  always_comb begin
    nextState = state;
    nextPHp   = p_hp;
    nextMonHp = mon_hp;
    nextWave  = wave_idx;
    nextCnt   = tickCnt;
    case (state)
      PH_IDLE: begin
        if (keyEnter) nextState = PH_MENU;
      end
      PH_MENU: begin
        if (keyAttack) begin
          nextState = PH_ATTACK;
        end else if (keyHeal) begin
          nextPHp   = (healSum > 9'(P_HP_INIT)) ? 8'(P_HP_INIT) : healSum[7:0];
          nextState = PH_DODGE;
          nextCnt   = '0;
        end
      end
      PH_ATTACK: begin
        if (atk_done) begin
          nextMonHp = monHpHit;
          nextState = (monHpHit == 8'd0) ? PH_WIN : PH_DODGE;
          nextCnt   = '0;
        end
      end
      PH_DODGE: begin
        if (tick) nextCnt = cntInc;
        if (hit_pulse) nextPHp = pHpHit;
        // A fatal hit wins over a coincident timeout, and leaves the wave alone.
        if (hit_pulse && (pHpHit == 8'd0)) begin
          nextState = PH_LOSE;
        end else if (tick && (cntInc == CNT_W'(DODGE_TICKS))) begin
          nextState = PH_MENU;
          nextWave  = waveInc;
        end
      end
      PH_WIN, PH_LOSE: begin
        if (keyRestart) begin
          nextState = PH_IDLE;
          nextPHp   = 8'(P_HP_INIT);
          nextMonHp = 8'(MON_HP_INIT);
          nextWave  = 3'd0;
          nextCnt   = '0;
        end
      end
      default: nextState = PH_IDLE;
    endcase

    nextAtkStart  = (state == PH_MENU) && (nextState == PH_ATTACK);
    nextBulletRun = (nextState == PH_DODGE);
    nextWin       = (nextState == PH_WIN);
    nextGameOver  = (nextState == PH_LOSE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= PH_IDLE;
      p_hp       <= 8'(P_HP_INIT);
      mon_hp     <= 8'(MON_HP_INIT);
      wave_idx   <= 3'd0;
      tickCnt    <= '0;
      atk_start  <= 1'b0;
      bullet_run <= 1'b0;
      win        <= 1'b0;
      game_over  <= 1'b0;
    end else begin
      state      <= nextState;
      p_hp       <= nextPHp;
      mon_hp     <= nextMonHp;
      wave_idx   <= nextWave;
      tickCnt    <= nextCnt;
      atk_start  <= nextAtkStart;
      bullet_run <= nextBulletRun;
      win        <= nextWin;
      game_over  <= nextGameOver;
    end
  end

endmodule

// File: tb/tb_battle_sequencer.sv
// Directed bench for battle_sequencer: vector table plus hand-written dodge/restart/reset sequences.
module tb_battle_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick, key_valid, atk_done, hit_pulse;
  logic [7:0] key, atk_dmg, hit_dmg;
  logic [2:0] phase, wave_idx;
  logic       atk_start, bullet_run, game_over, win;
  logic [7:0] mon_hp, p_hp;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int kv, key, tk, ad, admg, hp, hdmg;
    int ph, atk, run, wave, mon, p, go, wn;
  } vec_t;

  vec_t tbl [9];

  battle_sequencer dut (
    .clk(clk), .reset(reset), .tick(tick),
    .key_valid(key_valid), .key(key),
    .atk_done(atk_done), .atk_dmg(atk_dmg),
    .hit_pulse(hit_pulse), .hit_dmg(hit_dmg),
    .phase(phase), .atk_start(atk_start), .bullet_run(bullet_run),
    .wave_idx(wave_idx), .mon_hp(mon_hp), .p_hp(p_hp),
    .game_over(game_over), .win(win)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chkAll(input string nm, input int ph, input int atk, input int run,
                        input int wave, input int mon, input int p, input int go, input int wn);
    chk({nm, " phase"},      phase,      ph);
    chk({nm, " atk_start"},  atk_start,  atk);
    chk({nm, " bullet_run"}, bullet_run, run);
    chk({nm, " wave_idx"},   wave_idx,   wave);
    chk({nm, " mon_hp"},     mon_hp,     mon);
    chk({nm, " p_hp"},       p_hp,       p);
    chk({nm, " game_over"},  game_over,  go);
    chk({nm, " win"},        win,        wn);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    key_valid = 1'b0; tick = 1'b0; atk_done = 1'b0; hit_pulse = 1'b0;
    key = 8'h00; atk_dmg = 8'h00; hit_dmg = 8'h00;
  endtask

  task automatic ap(input vec_t v, input string nm);
    key_valid = 1'(v.kv); key = 8'(v.key); tick = 1'(v.tk);
    atk_done = 1'(v.ad); atk_dmg = 8'(v.admg);
    hit_pulse = 1'(v.hp); hit_dmg = 8'(v.hdmg);
    cyc();
    chkAll(nm, v.ph, v.atk, v.run, v.wave, v.mon, v.p, v.go, v.wn);
  endtask

  task automatic pressKey(input int k);
    key_valid = 1'b1; key = 8'(k);
    cyc();
  endtask

  task automatic attack(input int dmg);
    atk_done = 1'b1; atk_dmg = 8'(dmg);
    cyc();
  endtask

  // 49 quiet ticks, then the timeout tick (optionally with a coincident hit).
  task automatic tickOut(input string nm, input int hdmg, input int expPhase,
                         input int expWave, input int expP);
    for (int i = 1; i < 50; i++) begin
      tick = 1'b1;
      cyc();
    end
    chk({nm, " tick49 phase"}, phase, 3);
    chk({nm, " tick49 bullet_run"}, bullet_run, 1);
    tick = 1'b1;
    if (hdmg > 0) begin
      hit_pulse = 1'b1; hit_dmg = 8'(hdmg);
    end
    cyc();
    chk({nm, " timeout phase"}, phase, expPhase);
    chk({nm, " timeout wave_idx"}, wave_idx, expWave);
    chk({nm, " timeout p_hp"}, p_hp, expP);
    chk({nm, " timeout bullet_run"}, bullet_run, 0);
    chk({nm, " timeout game_over"}, game_over, (expPhase == 5) ? 1 : 0);
  endtask

  task automatic healDodge(input string nm, input int expP, input int expWave);
    pressKey(8'h68);
    chk({nm, " heal p_hp"}, p_hp, expP);
    chk({nm, " heal phase"}, phase, 3);
    tickOut(nm, 0, 1, expWave, expP);
  endtask

  initial begin
    //        kv key    tk ad admg hp hdmg  ph atk run wv mon  p    go wn
    tbl[0] = '{1, 8'h41, 0, 0, 0,  0, 0,    0, 0,  0,  0, 100, 100, 0, 0};
    tbl[1] = '{1, 8'h0D, 0, 0, 0,  0, 0,    1, 0,  0,  0, 100, 100, 0, 0};
    tbl[2] = '{1, 8'h72, 0, 0, 0,  0, 0,    1, 0,  0,  0, 100, 100, 0, 0};
    tbl[3] = '{1, 8'h61, 0, 0, 0,  0, 0,    2, 1,  0,  0, 100, 100, 0, 0};
    tbl[4] = '{0, 8'h00, 0, 0, 0,  0, 0,    2, 0,  0,  0, 100, 100, 0, 0};
    tbl[5] = '{1, 8'h68, 1, 0, 0,  1, 50,   2, 0,  0,  0, 100, 100, 0, 0};
    tbl[6] = '{0, 8'h00, 0, 1, 30, 0, 0,    3, 0,  1,  0, 70,  100, 0, 0};
    tbl[7] = '{0, 8'h00, 0, 0, 0,  1, 15,   3, 0,  1,  0, 70,  85,  0, 0};
    tbl[8] = '{1, 8'h61, 0, 0, 0,  0, 0,    3, 0,  1,  0, 70,  85,  0, 0};

    reset = 1'b1;
    key_valid = 1'b0; tick = 1'b0; atk_done = 1'b0; hit_pulse = 1'b0;
    key = 8'h00; atk_dmg = 8'h00; hit_dmg = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chkAll("reset", 0, 0, 0, 0, 100, 100, 0, 0);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) ap(tbl[i], $sformatf("vec%0d", i));

    // Non-fatal hit on the timeout tick: hit applied, still returns to MENU.
    tickOut("round0", 10, 1, 1, 75);
    healDodge("round1", 85, 2);
    healDodge("round2", 95, 3);
    healDodge("round3", 100, 4);
    healDodge("round4", 100, 5);
    healDodge("round5", 100, 6);
    healDodge("round6", 100, 7);
    healDodge("round7", 100, 0);

    pressKey(8'h61);
    attack(50);
    chkAll("atk50", 3, 0, 1, 0, 20, 100, 0, 0);
    tickOut("round8", 0, 1, 1, 100);
    pressKey(8'h61);
    attack(25);
    chkAll("killshot", 4, 0, 0, 1, 0, 100, 0, 1);
    pressKey(8'h0D);
    chkAll("win ignore", 4, 0, 0, 1, 0, 100, 0, 1);
    pressKey(8'h72);
    chkAll("win restart", 0, 0, 0, 0, 100, 100, 0, 0);

    pressKey(8'h0D);
    pressKey(8'h61);
    attack(10);
    chkAll("atk10", 3, 0, 1, 0, 90, 100, 0, 0);
    hit_pulse = 1'b1; hit_dmg = 8'd95;
    cyc();
    chk("hit95 p_hp", p_hp, 5);
    tickOut("fatal", 9, 5, 0, 0);
    chkAll("lose", 5, 0, 0, 0, 90, 0, 1, 0);
    hit_pulse = 1'b1; hit_dmg = 8'd1; tick = 1'b1;
    cyc();
    chkAll("lose ignore", 5, 0, 0, 0, 90, 0, 1, 0);
    pressKey(8'h72);
    chkAll("lose restart", 0, 0, 0, 0, 100, 100, 0, 0);

    pressKey(8'h0D);
    pressKey(8'h61);
    attack(10);
    hit_pulse = 1'b1; hit_dmg = 8'd7;
    cyc();
    repeat (3) begin
      tick = 1'b1;
      cyc();
    end
    chkAll("pre-reset", 3, 0, 1, 0, 90, 93, 0, 0);
    reset = 1'b1;
    #1;
    chkAll("async reset", 0, 0, 0, 0, 100, 100, 0, 0);
    cyc();
    reset = 1'b0;
    cyc();
    chk("post-reset idle", phase, 0);
    pressKey(8'h0D);
    chk("resume menu", phase, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/battle_sequencer.md
BATTLE_SEQUENCER -- requirements
Module: battle_sequencer

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- DODGE_TICKS, 50, tick strobes per dodge phase.
- P_HP_INIT, 100, player HP after reset or restart.
- MON_HP_INIT, 100, monster HP after reset or restart.
- HEAL_AMT, 10, HP restored by the heal action.
- NUM_WAVES, 8, number of bullet wave patterns; wave_idx wraps at this value.

REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, single system clock.
- reset, in, 1, asynchronous, active-high.
- tick, in, 1, one-cycle 10 Hz strobe in the clk domain.
- key_valid, in, 1, one-cycle qualifier for key.
- key, in, 8, ASCII byte from the UART receiver.
- atk_done, in, 1, one-cycle pulse: attack gauge finished.
- atk_dmg, in, 8, damage value; valid with atk_done.
- hit_pulse, in, 1, one-cycle pulse: bullet collided with player.
- hit_dmg, in, 8, damage value; valid with hit_pulse.
- phase, out, 3, current state code.
- atk_start, out, 1, one-cycle pulse that starts the attack gauge.
- bullet_run, out, 1, high while bullets are moving.
- wave_idx, out, 3, selects the bullet wave pattern.
- mon_hp, out, 8, monster HP.
- p_hp, out, 8, player HP.
- game_over, out, 1, high in LOSE.
- win, out, 1, high in WIN.

REQ-003 All outputs SHALL be registered.

Function
REQ-004 State codes SHALL be IDLE=0, MENU=1, ATTACK=2, DODGE=3, WIN=4, LOSE=5; phase SHALL equal the current code.
REQ-005 IDLE: key_valid with key=8'h0D SHALL move to MENU next cycle; every other key SHALL be ignored.
REQ-006 MENU, key 8'h61 ('a'): SHALL move to ATTACK and SHALL assert atk_start for exactly one cycle, the first cycle in ATTACK.
REQ-007 MENU, key 8'h68 ('h'): SHALL set p_hp to min(p_hp+HEAL_AMT, P_HP_INIT), computed at 9 bits, and SHALL move to DODGE.
REQ-008 MENU: all other keys SHALL be ignored.
REQ-009 ATTACK: atk_done SHALL set mon_hp to mon_hp-atk_dmg, saturating at 0. The next state SHALL be WIN if the result is 0, else DODGE.
REQ-010 ATTACK: keys, tick and hit_pulse SHALL be ignored.
REQ-011 On entry to DODGE, the tick counter SHALL clear to 0.
REQ-012 In DODGE, bullet_run SHALL be 1 and each tick SHALL increment the counter.
REQ-013 bullet_run SHALL be 0 in every state other than DODGE.
REQ-014 DODGE: hit_pulse SHALL set p_hp to p_hp-hit_dmg, saturating at 0. If the result is 0, the next state SHALL be LOSE.
REQ-015 DODGE timeout: the tick that brings the counter to DODGE_TICKS SHALL cause a move to MENU and an increment of wave_idx, wrapping from NUM_WAVES-1 to 0.
REQ-016 hit_pulse and the timeout tick in the same cycle: the hit SHALL be applied first. A zero p_hp SHALL go to LOSE with wave_idx unchanged; otherwise the move is to MENU.
REQ-017 hit_pulse outside DODGE SHALL be ignored.
REQ-018 WIN/LOSE: key 8'h72 ('r') SHALL reload p_hp, mon_hp, wave_idx=0 and counter=0, and SHALL move to IDLE. Other inputs SHALL be ignored.
REQ-019 win SHALL be 1 only in WIN; game_over SHALL be 1 only in LOSE.
REQ-020 The block SHALL respond to input pulses in the same cycle they are sampled; the state and outputs SHALL update on the following clk edge.

Reset
REQ-021 Asserting reset at any time, including mid-DODGE or mid-ATTACK, SHALL immediately force:
- phase=IDLE;
- p_hp=P_HP_INIT, mon_hp=MON_HP_INIT;
- wave_idx=0, counter=0;
- atk_start=0, bullet_run=0, win=0, game_over=0.
REQ-022 Operation SHALL resume on the first clk edge after reset is deasserted.

Structure
REQ-023 A shared package SHALL hold the phase codes, the key constants 8'h0D/8'h61/8'h68/8'h72 and the HP defaults.
REQ-024 One sub-module, sat_sub8 (8-bit subtract saturating at 0), SHALL be instantiated twice, once for player HP and once for monster HP.

Verification
REQ-025 Reset, then key 0x0D, then 'a' -> phase 0→1→2; atk_start high for exactly 1 cycle.
REQ-026 In ATTACK, atk_done with atk_dmg=30 -> mon_hp=70, phase=3, bullet_run=1.
REQ-027 In ATTACK with mon_hp=20, atk_done with atk_dmg=25 -> mon_hp=0, phase=4, win=1.
REQ-028 In DODGE with DODGE_TICKS=50, 50 ticks and no hits -> phase=1, wave_idx 7→0.
REQ-029 With p_hp=5, hit_dmg=9 and the timeout tick in the same cycle -> p_hp=0, phase=5, game_over=1, wave_idx unchanged.
REQ-030 With p_hp=95, 'h' -> p_hp=100. Reset asserted mid-DODGE -> all outputs return to reset values and bullet_run=0.
